// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Issue side of a combinational 16-bit ALU. Commands arrive over a valid/ready
// channel and are buffered in a small FIFO. They are issued to the ALU one at a
// time. One cycle later the ALU result and flags are captured and returned on
// a valid/ready response channel. The external ALU sits between alu_a / alu_b /
// alu_control (outputs) and alu_result / alu_zero / alu_overflow (inputs).
//
// Optional feature macro: ALU_SEQ_OVF_CNT_EN
//   When defined, adds ovf_clr (in) and ovf_count[15:0] (out). The counter
//   counts captured results with the overflow flag set and saturates at
//   16'hFFFF. A clear takes priority over an increment in the same cycle.
//
// Ports
//   clk, rst_n                   clock (rising edge), synchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (cmd_ready = FIFO not full)
//   cmd_op/cmd_a/cmd_b           opcode (0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT), operands
//   alu_a/alu_b/alu_control      registered operands and opcode driven to the ALU
//   alu_result/zero/overflow     combinational ALU outputs
//   rsp_valid/rsp_ready          response handshake
//   rsp_result/zero/overflow     captured ALU outputs
//   rsp_illegal                  captured opcode was 6..15
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_illegal
`ifdef ALU_SEQ_OVF_CNT_EN
  ,
  input  logic             ovf_clr,
  output logic [15:0]      ovf_count
`endif
);

  // state  | meaning
  // -------+-------------------------------------------------------------
  // S_IDLE | no command in flight; pops the FIFO head when one is queued
  // S_EXEC | operands on the ALU for one cycle, result captured at exit
  // S_RESP | response held on rsp_*; handshake may pop the next command

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [3:0]       op_mem [FIFO_DEPTH];
  logic [WIDTH-1:0] a_mem  [FIFO_DEPTH];
  logic [WIDTH-1:0] b_mem  [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;

  logic fifo_empty;
  logic push, pop, capture, rsp_done;

  assign fifo_empty = (count == '0);
  assign cmd_ready  = (count != FULL_CNT);
  assign push       = cmd_valid && cmd_ready;

  // ---------------------------------------------------------------- FIFO
  // Storage needs no reset; an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr] <= cmd_op;
      a_mem[wr_ptr]  <= cmd_a;
      b_mem[wr_ptr]  <= cmd_b;
    end
  end

  // Power-of-two depth, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!fifo_empty) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = fifo_empty ? S_IDLE : S_EXEC;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    case (state)
      S_IDLE: pop = !fifo_empty;
      S_EXEC: capture = 1'b1;
      S_RESP: begin
        rsp_done = rsp_ready;
        // Back-to-back issue: the next command goes out on the handshake edge.
        pop      = rsp_ready && !fifo_empty;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_control  <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_illegal  <= 1'b0;
    end else begin
      if (pop) begin
        alu_a       <= a_mem[rd_ptr];
        alu_b       <= b_mem[rd_ptr];
        alu_control <= op_mem[rd_ptr];
      end
      if (capture) begin
        rsp_valid    <= 1'b1;
        rsp_result   <= alu_result;
        rsp_zero     <= alu_zero;
        rsp_overflow <= alu_overflow;
        rsp_illegal  <= (alu_control > 4'd5);
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (ovf_clr) begin
      ovf_count <= '0;
    end else if (capture && alu_overflow && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Directed bench for alu_cmd_sequencer. A behavioural 16-bit ALU closes the
// loop between alu_* outputs and inputs; every expected response value below
// is written out by hand from the operands.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_control;
  logic [15:0] alu_result;
  logic        alu_zero;
  logic        alu_overflow;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_overflow;
  logic        rsp_illegal;
`ifdef ALU_SEQ_OVF_CNT_EN
  logic        ovf_clr;
  logic [15:0] ovf_count;
`endif

  int checks = 0;
  int errors = 0;

  alu_cmd_sequencer #(.WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_control  (alu_control),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_overflow (rsp_overflow),
    .rsp_illegal  (rsp_illegal)
`ifdef ALU_SEQ_OVF_CNT_EN
    ,
    .ovf_clr      (ovf_clr),
    .ovf_count    (ovf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU
  always_comb begin
    alu_result   = 16'h0000;
    alu_overflow = 1'b0;
    case (alu_control)
      4'd0: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[15] == alu_b[15]) && (alu_result[15] != alu_a[15]);
      end
      4'd1: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[15] != alu_b[15]) && (alu_result[15] != alu_a[15]);
      end
      4'd2: alu_result = alu_a & alu_b;
      4'd3: alu_result = alu_a | alu_b;
      4'd4: alu_result = alu_a ^ alu_b;
      4'd5: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 16'd1 : 16'd0;
      default: alu_result = 16'h0000;
    endcase
    alu_zero = (alu_result == 16'h0000);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic drive_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
  endtask

  // Drive one command for one edge (caller guarantees cmd_ready is high).
  task automatic send_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    drive_cmd(op, a, b);
    step();
    cmd_valid = 1'b0;
  endtask

  // Bounded wait for a response, check it, then let the handshake edge pass.
  task automatic expect_rsp(input string tag, input logic [15:0] r, input logic z,
                            input logic o, input logic il);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_valid"},    {31'd0, rsp_valid},    32'd1);
    check({tag, "_result"},   {16'd0, rsp_result},   {16'd0, r});
    check({tag, "_zero"},     {31'd0, rsp_zero},     {31'd0, z});
    check({tag, "_overflow"}, {31'd0, rsp_overflow}, {31'd0, o});
    check({tag, "_illegal"},  {31'd0, rsp_illegal},  {31'd0, il});
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 4'd0;
    cmd_a     = 16'd0;
    cmd_b     = 16'd0;
    rsp_ready = 1'b0;
`ifdef ALU_SEQ_OVF_CNT_EN
    ovf_clr   = 1'b0;
`endif

    // ---- reset state
    step();
    step();
    check("rst_cmd_ready",   {31'd0, cmd_ready},   32'd1);
    check("rst_rsp_valid",   {31'd0, rsp_valid},   32'd0);
    check("rst_alu_a",       {16'd0, alu_a},       32'd0);
    check("rst_alu_control", {28'd0, alu_control}, 32'd0);
    check("rst_rsp_result",  {16'd0, rsp_result},  32'd0);
    rst_n = 1'b1;
    step();

    // ---- 1: ADD overflow, latency 2 cycles after accept
    rsp_ready = 1'b1;
    send_cmd(4'd0, 16'h7FFF, 16'h0001);            // accepted at T0
    check("t1_valid_T0", {31'd0, rsp_valid}, 32'd0);
    step();                                        // T1: issued
    check("t1_valid_T1", {31'd0, rsp_valid}, 32'd0);
    check("t1_alu_a",    {16'd0, alu_a},     32'h7FFF);
    step();                                        // T2: captured
    check("t1_valid_T2", {31'd0, rsp_valid},    32'd1);
    check("t1_result",   {16'd0, rsp_result},   32'h8000);
    check("t1_overflow", {31'd0, rsp_overflow}, 32'd1);
    check("t1_zero",     {31'd0, rsp_zero},     32'd0);
    step();                                        // handshake
    check("t1_valid_after", {31'd0, rsp_valid}, 32'd0);

    // ---- 2: SUB 5-5 then SLT -1<1, in order
    send_cmd(4'd1, 16'd5, 16'd5);
    send_cmd(4'd5, 16'hFFFF, 16'd1);
    expect_rsp("t2_sub", 16'd0, 1'b1, 1'b0, 1'b0);
    expect_rsp("t2_slt", 16'd1, 1'b0, 1'b0, 1'b0);

    // ---- 4: illegal opcode forwarded, ALU returns 0
    send_cmd(4'hA, 16'd3, 16'd4);
    expect_rsp("t4_illegal", 16'd0, 1'b1, 1'b0, 1'b1);
    check("t4_alu_control_held", {28'd0, alu_control}, 32'hA);
    check("t4_alu_a_held",       {16'd0, alu_a},       32'd3);

    // ---- 3: back-pressure. The first command is popped while the later ones
    // arrive, so four pushes leave 3 queued and a fifth fills the FIFO.
    rsp_ready = 1'b0;
    send_cmd(4'd0, 16'd1, 16'd2);                  // 3
    send_cmd(4'd1, 16'd10, 16'd3);                 // 7
    send_cmd(4'd2, 16'hF0F0, 16'hFF00);            // F000
    send_cmd(4'd3, 16'h0F00, 16'h00F0);            // 0FF0
    check("t3_ready_after4", {31'd0, cmd_ready}, 32'd1);
    send_cmd(4'd4, 16'hFFFF, 16'h00FF);            // FF00
    check("t3_ready_full", {31'd0, cmd_ready}, 32'd0);
    drive_cmd(4'd0, 16'h1234, 16'h1111);           // must not be accepted
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_hold_valid",  {31'd0, rsp_valid},  32'd1);
      check("t3_hold_result", {16'd0, rsp_result}, 32'd3);
      check("t3_hold_ready",  {31'd0, cmd_ready},  32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    expect_rsp("t3_r1", 16'd3,     1'b0, 1'b0, 1'b0);
    expect_rsp("t3_r2", 16'd7,     1'b0, 1'b0, 1'b0);
    expect_rsp("t3_r3", 16'hF000,  1'b0, 1'b0, 1'b0);
    expect_rsp("t3_r4", 16'h0FF0,  1'b0, 1'b0, 1'b0);
    expect_rsp("t3_r5", 16'hFF00,  1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("t3_no_extra", {31'd0, rsp_valid}, 32'd0);
      step();
    end
    check("t3_ready_drained", {31'd0, cmd_ready}, 32'd1);

    // ---- 5: reset while RESP with 2 queued
    rsp_ready = 1'b0;
    send_cmd(4'd0, 16'd1, 16'd1);
    send_cmd(4'd0, 16'd2, 16'd2);
    send_cmd(4'd0, 16'd3, 16'd3);
    check("t5_in_resp", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5_rst_valid",  {31'd0, rsp_valid},  32'd0);
    check("t5_rst_ready",  {31'd0, cmd_ready},  32'd1);
    check("t5_rst_result", {16'd0, rsp_result}, 32'd0);
    check("t5_rst_alu_a",  {16'd0, alu_a},      32'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t5_no_stale", {31'd0, rsp_valid}, 32'd0);
    end

`ifdef ALU_SEQ_OVF_CNT_EN
    // ---- 6: overflow counter
    check("t6_cnt_after_rst", {16'd0, ovf_count}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      send_cmd(4'd0, 16'h7FFF, 16'h0001);
      expect_rsp("t6_ovf_add", 16'h8000, 1'b0, 1'b1, 1'b0);
    end
    check("t6_cnt3", {16'd0, ovf_count}, 32'd3);
    send_cmd(4'd0, 16'h7FFF, 16'h0001);            // accept edge
    step();                                        // issue edge, now in EXEC
    ovf_clr = 1'b1;
    step();                                        // capture edge with clear
    ovf_clr = 1'b0;
    check("t6_clr_wins", {16'd0, ovf_count}, 32'd0);
    check("t6_clr_rsp_ovf", {31'd0, rsp_overflow}, 32'd1);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
